traffic_intersection_ctrl: RTL and testbench

//  Phase sequencer for a two-road intersection (main street / side street).

---
 rtl/traffic_intersection_ctrl.sv | 159 +++++++++++++++
 tb/tb_traffic_intersection_ctrl.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_intersection_ctrl.sv
// Two-road intersection phase sequencer: main green by default, timed side-street
// service for sensor/pedestrian requests, and emergency all-red override.
//
// state | meaning
// ST_MG  | main green (default, holds until request after minimum green)
// ST_MY  | main yellow
// ST_AR1 | all-red clearance after main
// ST_SG  | side green (walk active if a pedestrian was served)
// ST_SY  | side yellow
// ST_AR2 | all-red clearance after side
module traffic_intersection_ctrl #(
    parameter int GREEN_MAIN_MIN = 8,
    parameter int GREEN_SIDE     = 6,
    parameter int YELLOW         = 3,
    parameter int ALL_RED        = 2,
    parameter int CNT_W          = 8
) (
    input  logic       clk,
    input  logic       areset_n,
    input  logic       side_sensor,
    input  logic       ped_btn,
    input  logic       emerg,
    output logic [1:0] main_light,
    output logic [1:0] side_light,
    output logic       walk,
    output logic [2:0] phase
);

    typedef enum logic [2:0] {
        ST_MG  = 3'd0,
        ST_MY  = 3'd1,
        ST_AR1 = 3'd2,
        ST_SG  = 3'd3,
        ST_SY  = 3'd4,
        ST_AR2 = 3'd5
    } state_t;

    localparam logic [1:0] LIGHT_RED    = 2'b00;
    localparam logic [1:0] LIGHT_GREEN  = 2'b01;
    localparam logic [1:0] LIGHT_YELLOW = 2'b10;

    localparam logic [CNT_W-1:0] MG_MIN_LAST = CNT_W'(GREEN_MAIN_MIN - 1);
    localparam logic [CNT_W-1:0] SG_LAST     = CNT_W'(GREEN_SIDE - 1);
    localparam logic [CNT_W-1:0] YEL_LAST    = CNT_W'(YELLOW - 1);
    localparam logic [CNT_W-1:0] AR_LAST     = CNT_W'(ALL_RED - 1);
    localparam logic [CNT_W-1:0] TIMER_MAX   = {CNT_W{1'b1}};

    state_t           state_q, state_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic             ped_pend_q, ped_pend_d;
    logic             emerg_seen_q, emerg_seen_d;
    logic             walk_en_q, walk_en_d;

    logic state_change;
    logic sg_entry;
    logic sg_exit;
    logic in_all_red;

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            state_q      <= ST_MG;
            timer_q      <= '0;
            ped_pend_q   <= 1'b0;
            emerg_seen_q <= 1'b0;
            walk_en_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            ped_pend_q   <= ped_pend_d;
            emerg_seen_q <= emerg_seen_d;
            walk_en_q    <= walk_en_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_MG: begin
                if (emerg ||
                    ((timer_q >= MG_MIN_LAST) && (side_sensor || ped_pend_q || ped_btn)))
                    state_d = ST_MY;
            end
            ST_MY: begin
                if (timer_q == YEL_LAST)
                    state_d = ST_AR1;
            end
            ST_AR1, ST_AR2: begin
                // After an emergency the side phase is skipped; main green resumes.
                if (!emerg && (timer_q == AR_LAST)) begin
                    if (emerg_seen_q || (state_q == ST_AR2))
                        state_d = ST_MG;
                    else
                        state_d = ST_SG;
                end
            end
            ST_SG: begin
                if (emerg || (timer_q == SG_LAST))
                    state_d = ST_SY;
            end
            ST_SY: begin
                if (timer_q == YEL_LAST)
                    state_d = ST_AR2;
            end
            default: state_d = ST_MG;
        endcase
    end

    assign state_change = (state_d != state_q);
    assign sg_entry     = (state_d == ST_SG) && (state_q != ST_SG);
    assign sg_exit      = (state_q == ST_SG) && (state_d != ST_SG);
    assign in_all_red   = (state_q == ST_AR1) || (state_q == ST_AR2);

    always_comb begin
        timer_d = timer_q;
        if (state_change)
            timer_d = '0;
        else if (in_all_red && emerg)
            timer_d = '0;
        else if (timer_q != TIMER_MAX)
            timer_d = timer_q + 1'b1;
    end

    // The request consumed at side-green entry decides walk for that whole phase.
    always_comb begin
        ped_pend_d = ped_pend_q | ped_btn;
        walk_en_d  = walk_en_q;
        if (sg_entry) begin
            ped_pend_d = 1'b0;
            walk_en_d  = ped_pend_q | ped_btn;
        end else if (sg_exit) begin
            walk_en_d  = 1'b0;
        end
    end

    always_comb begin
        emerg_seen_d = emerg_seen_q | emerg;
        if (state_change && ((state_d == ST_MG) || (state_d == ST_SG)))
            emerg_seen_d = 1'b0;
    end

    always_comb begin
        main_light = LIGHT_RED;
        side_light = LIGHT_RED;
        case (state_q)
            ST_MG: main_light = LIGHT_GREEN;
            ST_MY: main_light = LIGHT_YELLOW;
            ST_SG: side_light = LIGHT_GREEN;
            ST_SY: side_light = LIGHT_YELLOW;
            default: begin
                main_light = LIGHT_RED;
                side_light = LIGHT_RED;
            end
        endcase
    end

    assign walk  = walk_en_q && (state_q == ST_SG);
    assign phase = state_q;

endmodule

// File: tb/tb_traffic_intersection_ctrl.sv
// Scoreboard bench for traffic_intersection_ctrl: directed timelines plus random
// traffic checked against a phase/age reference model.
module tb_traffic_intersection_ctrl;

    localparam int GMIN = 8;
    localparam int GS   = 6;
    localparam int YEL  = 3;
    localparam int ARC  = 2;

    localparam int P_MG  = 0;
    localparam int P_MY  = 1;
    localparam int P_AR1 = 2;
    localparam int P_SG  = 3;
    localparam int P_SY  = 4;
    localparam int P_AR2 = 5;

    logic       clk = 1'b0;
    logic       areset_n = 1'b0;
    logic       side_sensor = 1'b0;
    logic       ped_btn = 1'b0;
    logic       emerg = 1'b0;
    logic [1:0] main_light;
    logic [1:0] side_light;
    logic       walk;
    logic [2:0] phase;

    always #5 clk = ~clk;

    traffic_intersection_ctrl #(
        .GREEN_MAIN_MIN(GMIN),
        .GREEN_SIDE    (GS),
        .YELLOW        (YEL),
        .ALL_RED       (ARC),
        .CNT_W         (8)
    ) dut (
        .clk        (clk),
        .areset_n   (areset_n),
        .side_sensor(side_sensor),
        .ped_btn    (ped_btn),
        .emerg      (emerg),
        .main_light (main_light),
        .side_light (side_light),
        .walk       (walk),
        .phase      (phase)
    );

    typedef struct packed {
        logic [1:0] ml;
        logic [1:0] sl;
        logic       wk;
        logic [2:0] ph;
    } obs_t;

    obs_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    // Reference model: which phase we are in and how long we have been there.
    int m_ph;
    int m_age;
    bit m_ped;
    bit m_seen;
    bit m_walk;

    int main_tab[6] = '{1, 2, 0, 0, 0, 0};
    int side_tab[6] = '{0, 0, 0, 1, 2, 0};

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task model_reset();
        m_ph = P_MG; m_age = 0; m_ped = 0; m_seen = 0; m_walk = 0;
    endtask

    function automatic int phase_len(input int ph);
        case (ph)
            P_MY, P_SY:   return YEL;
            P_AR1, P_AR2: return ARC;
            P_SG:         return GS;
            default:      return GMIN;
        endcase
    endfunction

    task model_step(input bit s, input bit pb, input bit e);
        int  nxt;
        bit  expired;
        expired = (m_age + 1 == phase_len(m_ph));
        nxt = m_ph;
        case (m_ph)
            P_MG:  if (e || (m_age + 1 >= GMIN && (s || m_ped || pb))) nxt = P_MY;
            P_MY:  if (expired) nxt = P_AR1;
            P_AR1: if (!e && expired) nxt = m_seen ? P_MG : P_SG;
            P_AR2: if (!e && expired) nxt = P_MG;
            P_SG:  if (e || expired) nxt = P_SY;
            P_SY:  if (expired) nxt = P_AR2;
            default: nxt = P_MG;
        endcase
        if (nxt == P_SG && m_ph != P_SG) begin
            m_walk = m_ped || pb;
            m_ped  = 0;
        end else begin
            m_ped = m_ped || pb;
            if (m_ph == P_SG && nxt != P_SG) m_walk = 0;
        end
        if (nxt != m_ph && (nxt == P_MG || nxt == P_SG)) m_seen = 0;
        else m_seen = m_seen || e;
        if (nxt != m_ph || (e && (m_ph == P_AR1 || m_ph == P_AR2))) m_age = 0;
        else if (m_age < 255) m_age++;
        m_ph = nxt;
    endtask

    function automatic obs_t model_obs();
        obs_t o;
        o.ml = 2'(main_tab[m_ph]);
        o.sl = 2'(side_tab[m_ph]);
        o.wk = m_walk && (m_ph == P_SG);
        o.ph = 3'(m_ph);
        return o;
    endfunction

    // Monitor: compares the DUT against the oldest pending expectation each cycle.
    always @(negedge clk) begin
        obs_t e;
        obs_t a;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a.ml = main_light; a.sl = side_light; a.wk = walk; a.ph = phase;
            checks++;
            if (a != e) begin
                errors++;
                $display("FAIL sb_obs: got main=%0d side=%0d walk=%0d phase=%0d, expected main=%0d side=%0d walk=%0d phase=%0d (t=%0t)",
                         a.ml, a.sl, a.wk, a.ph, e.ml, e.sl, e.wk, e.ph, $time);
            end
        end
    end

    task tick(input bit s, input bit p, input bit e);
        side_sensor = s; ped_btn = p; emerg = e;
        @(posedge clk);
        #1;
        model_step(s, p, e);
        exp_q.push_back(model_obs());
    endtask

    task do_reset(input string nm);
        @(negedge clk);
        #1;
        areset_n = 1'b0;
        side_sensor = 1'b0; ped_btn = 1'b0; emerg = 1'b0;
        #1;
        chk({nm, "_async"}, int'({main_light, side_light, walk, phase}), int'({2'b01, 2'b00, 1'b0, 3'd0}));
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        areset_n = 1'b1;
        model_reset();
    endtask

    int t3_cyc[12] = '{7, 8, 10, 11, 12, 13, 18, 19, 21, 22, 23, 24};
    int t3_ph[12]  = '{0, 1, 1, 2, 2, 3, 3, 4, 4, 5, 5, 0};
    int t5_cyc[7]  = '{15, 16, 18, 19, 25, 26, 27};
    int t5_ph[7]   = '{3, 4, 4, 5, 5, 5, 0};
    int t6_cyc[8]  = '{4, 6, 7, 8, 9, 16, 17, 22};
    int t6_ph[8]   = '{1, 1, 2, 2, 0, 0, 1, 3};

    initial begin
        int em_left;
        model_reset();
        do_reset("reset_init");

        // Idle: main green holds, including after the timer saturates.
        for (int c = 0; c < 100; c++) tick(0, 0, 0);
        chk("idle_100", int'(phase), P_MG);
        for (int c = 0; c < 300; c++) tick(0, 0, 0);
        tick(1, 0, 0);
        chk("sat_side_req", int'(phase), P_MY);

        // Side sensor timeline.
        do_reset("reset_t3");
        for (int c = 0; c < 30; c++) begin
            tick(c < 24, 0, 0);
            for (int k = 0; k < 12; k++)
                if (t3_cyc[k] == c + 1) chk($sformatf("t3_cyc%0d", c + 1), int'(phase), t3_ph[k]);
        end

        // Pedestrian: walk exactly during the served side green; second press served later.
        do_reset("reset_t4");
        for (int c = 0; c < 60; c++) begin
            tick(0, (c == 2) || (c == 15), 0);
            if (c + 1 == 12) chk("t4_walk12", int'(walk), 0);
            if (c + 1 == 13) chk("t4_walk13", int'(walk), 1);
            if (c + 1 == 18) chk("t4_walk18", int'(walk), 1);
            if (c + 1 == 19) chk("t4_walk19", int'(walk), 0);
        end

        // Emergency during side green with walk active.
        do_reset("reset_t5");
        for (int c = 0; c < 40; c++) begin
            tick(c < 8, c == 2, (c >= 15) && (c <= 24));
            for (int k = 0; k < 7; k++)
                if (t5_cyc[k] == c + 1) chk($sformatf("t5_cyc%0d", c + 1), int'(phase), t5_ph[k]);
            if (c + 1 == 15) chk("t5_walk15", int'(walk), 1);
            if (c + 1 == 16) chk("t5_walk16", int'(walk), 0);
        end

        // Emergency in main green skips the side phase.
        do_reset("reset_t6");
        for (int c = 0; c < 30; c++) begin
            tick(1, 0, c == 3);
            for (int k = 0; k < 8; k++)
                if (t6_cyc[k] == c + 1) chk($sformatf("t6_cyc%0d", c + 1), int'(phase), t6_ph[k]);
        end

        // Reset mid side green with walk on.
        do_reset("reset_t1pre");
        for (int c = 0; c < 15; c++) tick(0, c == 2, 0);
        chk("t1_in_sg", int'(phase), P_SG);
        chk("t1_walk_on", int'(walk), 1);
        do_reset("t1_mid_sg");

        // Random traffic with emergency bursts and occasional resets.
        em_left = 0;
        for (int c = 0; c < 4000; c++) begin
            bit e;
            if (em_left > 0) begin
                e = 1; em_left--;
            end else begin
                e = 0;
                if ($urandom_range(0, 60) == 0) em_left = $urandom_range(1, 12);
            end
            tick($urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0, e);
            if ($urandom_range(0, 999) == 0) do_reset("rand_reset");
        end

        @(negedge clk);
        #1;
        chk("sb_drain", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
